// File: rtl/kmeans_centroid_update_k2_d4.sv
`default_nettype none
// ============================================================================
//  Module      : kmeans_centroid_update_k2_d4
//  Description : Centroid update stage for k=2, d=4 k-means. Accumulates the
//                classified point stream into per-centroid coordinate sums
//                and point counts over one epoch. It then divides each sum by
//                its count with a shared restoring divider and publishes all
//                eight new coordinates at once.
//  Ports       : clk, rst                  clock / async active-high reset
//                init_*_i                  centroid preload (IDLE only)
//                start_i                   open an epoch (IDLE -> ACC)
//                in_valid_i / in_ready_o   point stream handshake
//                input_data0..3_i          point coordinates
//                selected_centroid_i       cluster of the point
//                last_i                    final point of the epoch
//                busy_o, done_o            status / publish pulse
//                overflow_o                sticky: a point was dropped
//                centroid{0,1}_d{0..3}_o   current centroids
//  Revision    : 1.0 - initial release
// ============================================================================
module kmeans_centroid_update_k2_d4 #(
  parameter int INPUT_DATA_WIDTH = 16,
  parameter int COUNT_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        init_we_i,
  input  logic                        init_idx_i,
  input  logic [1:0]                  init_dim_i,
  input  logic [INPUT_DATA_WIDTH-1:0] init_data_i,
  input  logic                        start_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data0_i,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data1_i,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data2_i,
  input  logic [INPUT_DATA_WIDTH-1:0] input_data3_i,
  input  logic                        selected_centroid_i,
  input  logic                        last_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        overflow_o,
  output logic [INPUT_DATA_WIDTH-1:0] centroid0_d0_o,
  output logic [INPUT_DATA_WIDTH-1:0] centroid0_d1_o,
  output logic [INPUT_DATA_WIDTH-1:0] centroid0_d2_o,
  output logic [INPUT_DATA_WIDTH-1:0] centroid0_d3_o,
  output logic [INPUT_DATA_WIDTH-1:0] centroid1_d0_o,
  output logic [INPUT_DATA_WIDTH-1:0] centroid1_d1_o,
  output logic [INPUT_DATA_WIDTH-1:0] centroid1_d2_o,
  output logic [INPUT_DATA_WIDTH-1:0] centroid1_d3_o
);

  localparam int IW  = INPUT_DATA_WIDTH;
  localparam int CW  = COUNT_WIDTH;
  localparam int SW  = IW + CW;
  localparam int ITW = $clog2(SW + 1);
  localparam logic [ITW-1:0] IT_LAST = ITW'(SW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e          state_q;
  logic [SW-1:0]   sum_q    [2][4];
  logic [CW-1:0]   cnt_q    [2];
  logic [IW-1:0]   cent_q   [2][4];
  logic [IW-1:0]   shadow_q [2][4];
  logic            overflow_q;

  // Divider datapath: slot_q selects {k, d}; it_q = 0 is the load cycle,
  // it_q = 1..SW are the quotient-bit iterations.
  logic [2:0]      slot_q;
  logic [ITW-1:0]  it_q;
  logic [SW-1:0]   dvd_q;
  logic [CW-1:0]   dvs_q;
  logic [CW-1:0]   rem_q;
  logic [IW-1:0]   quo_q;

  logic [IW-1:0]   pt [4];
  assign pt[0] = input_data0_i;
  assign pt[1] = input_data1_i;
  assign pt[2] = input_data2_i;
  assign pt[3] = input_data3_i;

  logic            slot_k;
  logic [1:0]      slot_dim;
  logic [CW:0]     trial_d;
  logic [CW:0]     diff_d;
  logic            ge_d;
  logic [CW-1:0]   rem_d;
  logic [IW-1:0]   quo_d;
  logic [IW-1:0]   result_d;

  always_comb begin
    slot_k   = slot_q[2];
    slot_dim = slot_q[1:0];
    // Shift the next dividend bit into the partial remainder and try to
    // subtract the divisor; no borrow means the quotient bit is 1.
    trial_d  = {rem_q, dvd_q[SW-1]};
    diff_d   = trial_d - {1'b0, dvs_q};
    ge_d     = ~diff_d[CW];
    rem_d    = ge_d ? diff_d[CW-1:0] : trial_d[CW-1:0];
    // Only the low IW quotient bits are kept; the mean of IW-bit values
    // never needs more, so bits shifted past the top are always zero.
    quo_d    = {quo_q[IW-2:0], ge_d};
    // An empty cluster keeps its previous centroid.
    result_d = (dvs_q == '0) ? cent_q[slot_k][slot_dim] : quo_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      overflow_q <= 1'b0;
      slot_q     <= '0;
      it_q       <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      for (int k = 0; k < 2; k++) begin
        cnt_q[k] <= '0;
        for (int d = 0; d < 4; d++) begin
          sum_q[k][d]    <= '0;
          cent_q[k][d]   <= '0;
          shadow_q[k][d] <= '0;
        end
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (init_we_i) begin
            cent_q[init_idx_i][init_dim_i] <= init_data_i;
          end
          if (start_i) begin
            overflow_q <= 1'b0;
            for (int k = 0; k < 2; k++) begin
              cnt_q[k] <= '0;
              for (int d = 0; d < 4; d++) begin
                sum_q[k][d] <= '0;
              end
            end
            state_q <= ST_ACC;
          end
        end

        ST_ACC: begin
          // in_ready is high throughout ACC, so in_valid alone is the handshake.
          if (in_valid_i) begin
            if (cnt_q[selected_centroid_i] == '1) begin
              overflow_q <= 1'b1;
            end else begin
              cnt_q[selected_centroid_i] <= cnt_q[selected_centroid_i] + CW'(1);
              for (int d = 0; d < 4; d++) begin
                sum_q[selected_centroid_i][d] <= sum_q[selected_centroid_i][d] + SW'(pt[d]);
              end
            end
            if (last_i) begin
              slot_q  <= '0;
              it_q    <= '0;
              state_q <= ST_DIV;
            end
          end
        end

        ST_DIV: begin
          if (it_q == '0) begin
            dvd_q <= sum_q[slot_k][slot_dim];
            dvs_q <= cnt_q[slot_k];
            rem_q <= '0;
            quo_q <= '0;
            it_q  <= it_q + ITW'(1);
          end else begin
            dvd_q <= dvd_q << 1;
            rem_q <= rem_d;
            quo_q <= quo_d;
            if (it_q == IT_LAST) begin
              shadow_q[slot_k][slot_dim] <= result_d;
              it_q <= '0;
              if (slot_q == 3'd7) begin
                // Publish all shadows together; slot 7 is still being
                // written this edge, so it is taken from the divider directly.
                for (int k = 0; k < 2; k++) begin
                  for (int d = 0; d < 4; d++) begin
                    cent_q[k][d] <= shadow_q[k][d];
                  end
                end
                cent_q[1][3] <= result_d;
                state_q      <= ST_DONE;
              end else begin
                slot_q <= slot_q + 3'd1;
              end
            end else begin
              it_q <= it_q + ITW'(1);
            end
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Status outputs are pure decodes of the state register.
  assign in_ready_o = (state_q == ST_ACC);
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign overflow_o = overflow_q;

  assign centroid0_d0_o = cent_q[0][0];
  assign centroid0_d1_o = cent_q[0][1];
  assign centroid0_d2_o = cent_q[0][2];
  assign centroid0_d3_o = cent_q[0][3];
  assign centroid1_d0_o = cent_q[1][0];
  assign centroid1_d1_o = cent_q[1][1];
  assign centroid1_d2_o = cent_q[1][2];
  assign centroid1_d3_o = cent_q[1][3];

endmodule
`default_nettype wire

// File: tb/tb_kmeans_centroid_update_k2_d4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kmeans_centroid_update_k2_d4
//  Description : Self-checking bench. A default instance (16/16) and a
//                saturation instance (COUNT_WIDTH=2) share one stimulus
//                stream. Expected centroid sets are pushed to a scoreboard
//                when the last point is driven and popped on done.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_kmeans_centroid_update_k2_d4;

  localparam int LAT     = 8 * (16 + 16 + 1);  // 264
  localparam int LAT_SAT = 8 * (16 + 2 + 1);   // 152

  typedef logic [7:0][15:0] cset_t;            // index k*4+d

  logic        clk = 1'b0;
  logic        rst;
  logic        init_we, init_idx, start, in_valid, sel, last;
  logic [1:0]  init_dim;
  logic [15:0] init_data, d0, d1, d2, d3;

  logic        in_ready, busy, done, overflow;
  logic [15:0] c00, c01, c02, c03, c10, c11, c12, c13;
  logic        s_in_ready, s_busy, s_done, s_overflow;
  logic [15:0] s00, s01, s02, s03, s10, s11, s12, s13;

  logic [15:0] dut_c [8];
  logic [15:0] sat_c [8];
  assign dut_c = '{c00, c01, c02, c03, c10, c11, c12, c13};
  assign sat_c = '{s00, s01, s02, s03, s10, s11, s12, s13};

  always #5 clk = ~clk;

  kmeans_centroid_update_k2_d4 dut (
    .clk(clk), .rst(rst),
    .init_we_i(init_we), .init_idx_i(init_idx), .init_dim_i(init_dim), .init_data_i(init_data),
    .start_i(start), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .input_data0_i(d0), .input_data1_i(d1), .input_data2_i(d2), .input_data3_i(d3),
    .selected_centroid_i(sel), .last_i(last),
    .busy_o(busy), .done_o(done), .overflow_o(overflow),
    .centroid0_d0_o(c00), .centroid0_d1_o(c01), .centroid0_d2_o(c02), .centroid0_d3_o(c03),
    .centroid1_d0_o(c10), .centroid1_d1_o(c11), .centroid1_d2_o(c12), .centroid1_d3_o(c13)
  );

  kmeans_centroid_update_k2_d4 #(.INPUT_DATA_WIDTH(16), .COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst),
    .init_we_i(init_we), .init_idx_i(init_idx), .init_dim_i(init_dim), .init_data_i(init_data),
    .start_i(start), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
    .input_data0_i(d0), .input_data1_i(d1), .input_data2_i(d2), .input_data3_i(d3),
    .selected_centroid_i(sel), .last_i(last),
    .busy_o(s_busy), .done_o(s_done), .overflow_o(s_overflow),
    .centroid0_d0_o(s00), .centroid0_d1_o(s01), .centroid0_d2_o(s02), .centroid0_d3_o(s03),
    .centroid1_d0_o(s10), .centroid1_d1_o(s11), .centroid1_d2_o(s12), .centroid1_d3_o(s13)
  );

  int      n_pass  = 0;
  int      n_total = 0;
  cset_t   m_pub;            // centroids the default DUT should be showing now
  longint  m_sum [2][4];
  int      m_cnt [2];
  cset_t   exp_q [$];

  // Scoreboard pop on done, plus a per-cycle check that published centroids
  // only change when the bench expects them to.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_pop: done pulse with no expected entry (queue size 0, required >0)");
        end else begin
          cset_t e;
          e = exp_q.pop_front();
          n_pass++;
          for (int i = 0; i < 8; i++) begin
            n_total++;
            if (dut_c[i] !== e[i]) $display("FAIL sb_centroid[%0d]: got %0d required %0d", i, dut_c[i], e[i]);
            else n_pass++;
          end
        end
      end
      for (int i = 0; i < 8; i++) begin
        n_total++;
        if (dut_c[i] !== m_pub[i]) $display("FAIL stable_centroid[%0d]: got %0d required %0d", i, dut_c[i], m_pub[i]);
        else n_pass++;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic init_write(input logic k, input logic [1:0] dm, input logic [15:0] v);
    init_we = 1'b1; init_idx = k; init_dim = dm; init_data = v;
    @(posedge clk); #1;
    init_we = 1'b0;
    m_pub[k*4+dm] = v;
  endtask

  task automatic init_all(input logic k, input logic [15:0] v);
    for (int dm = 0; dm < 4; dm++) init_write(k, 2'(dm), v);
  endtask

  task automatic start_epoch();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      for (int dm = 0; dm < 4; dm++) m_sum[k][dm] = 0;
    end
  endtask

  task automatic send_point(input logic k, input logic [15:0] a, b, c, e, input logic lst);
    in_valid = 1'b1; sel = k; d0 = a; d1 = b; d2 = c; d3 = e; last = lst;
    @(posedge clk); #1;
    in_valid = 1'b0; last = 1'b0;
    m_cnt[k]++;
    m_sum[k][0] += a; m_sum[k][1] += b; m_sum[k][2] += c; m_sum[k][3] += e;
    if (lst) begin
      cset_t nx;
      for (int kk = 0; kk < 2; kk++)
        for (int dm = 0; dm < 4; dm++)
          nx[kk*4+dm] = (m_cnt[kk] == 0) ? m_pub[kk*4+dm] : 16'(m_sum[kk][dm] / m_cnt[kk]);
      exp_q.push_back(nx);
    end
  endtask

  // Returns the number of edges until done is seen, or -1 if the budget runs out.
  task automatic wait_main_done(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = i;
        if (exp_q.size() != 0) m_pub = exp_q[0];
        break;
      end
    end
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    n_total++;
    if ({busy, in_ready, done, overflow} !== 4'b0000) $display("FAIL reset_status: got %b required 0000", {busy, in_ready, done, overflow});
    else n_pass++;
    init_all(1'b0, 16'd7);
    start_epoch();
    send_point(1'b0, 16'd1, 16'd2, 16'd3, 16'd4, 1'b0);
    #2 rst = 1'b1;
    m_pub = '0;
    #1;
    for (int i = 0; i < 8; i++) begin
      n_total++;
      if (dut_c[i] !== 16'd0) $display("FAIL reset_centroid[%0d]: got %0d required 0", i, dut_c[i]);
      else n_pass++;
    end
    n_total++;
    if ({busy, in_ready, done, overflow} !== 4'b0000) $display("FAIL reset_midstream_status: got %b required 0000", {busy, in_ready, done, overflow});
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if ({busy, in_ready} !== 2'b00) $display("FAIL reset_release: got %b required 00", {busy, in_ready});
    else n_pass++;
  endtask

  task automatic test_basic_mean();
    int cyc;
    init_all(1'b0, 16'd0);
    init_all(1'b1, 16'd50);
    start_epoch();
    n_total++;
    if ({busy, in_ready} !== 2'b11) $display("FAIL acc_status: got %b required 11", {busy, in_ready});
    else n_pass++;
    send_point(1'b0, 16'd2, 16'd4, 16'd6, 16'd8, 1'b0);
    send_point(1'b0, 16'd4, 16'd6, 16'd8, 16'd10, 1'b0);
    send_point(1'b1, 16'd10, 16'd10, 16'd10, 16'd10, 1'b1);
    wait_main_done(LAT + 50, cyc);
    n_total++;
    if (cyc != LAT) $display("FAIL basic_latency: got %0d required %0d", cyc, LAT);
    else n_pass++;
    n_total++;
    if ({c00, c01, c02, c03} !== {16'd3, 16'd5, 16'd7, 16'd9}) $display("FAIL basic_c0: got %0d,%0d,%0d,%0d required 3,5,7,9", c00, c01, c02, c03);
    else n_pass++;
    n_total++;
    if ({c10, c11, c12, c13} !== {4{16'd10}}) $display("FAIL basic_c1: got %0d,%0d,%0d,%0d required 10,10,10,10", c10, c11, c12, c13);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({busy, done} !== 2'b00) $display("FAIL basic_after_done: got %b required 00", {busy, done});
    else n_pass++;
  endtask

  task automatic test_floor();
    int cyc;
    start_epoch();
    send_point(1'b0, 16'd1, 16'd1, 16'd1, 16'd1, 1'b0);
    send_point(1'b0, 16'd2, 16'd2, 16'd2, 16'd2, 1'b0);
    send_point(1'b0, 16'd2, 16'd2, 16'd2, 16'd2, 1'b1);
    wait_main_done(LAT + 50, cyc);
    n_total++;
    if (cyc != LAT) $display("FAIL floor_latency: got %0d required %0d", cyc, LAT);
    else n_pass++;
    n_total++;
    if ({c00, c01, c02, c03} !== {4{16'd1}}) $display("FAIL floor_c0: got %0d,%0d,%0d,%0d required 1,1,1,1", c00, c01, c02, c03);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_empty_cluster();
    int cyc;
    init_all(1'b1, 16'd100);
    start_epoch();
    send_point(1'b0, 16'd5, 16'd6, 16'd7, 16'd8, 1'b0);
    send_point(1'b0, 16'd7, 16'd8, 16'd9, 16'd10, 1'b1);
    wait_main_done(LAT + 50, cyc);
    n_total++;
    if (cyc != LAT) $display("FAIL empty_latency: got %0d required %0d", cyc, LAT);
    else n_pass++;
    n_total++;
    if ({c10, c11, c12, c13} !== {4{16'd100}}) $display("FAIL empty_c1: got %0d,%0d,%0d,%0d required 100 x4", c10, c11, c12, c13);
    else n_pass++;
    n_total++;
    if ({c00, c01, c02, c03} !== {16'd6, 16'd7, 16'd8, 16'd9}) $display("FAIL empty_c0: got %0d,%0d,%0d,%0d required 6,7,8,9", c00, c01, c02, c03);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_ignored_controls();
    int cyc;
    // Points (even with last) offered in IDLE must not be taken.
    in_valid = 1'b1; last = 1'b1; sel = 1'b0; d0 = 16'd900; d1 = 16'd900; d2 = 16'd900; d3 = 16'd900;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_total++;
      if ({busy, in_ready} !== 2'b00) $display("FAIL idle_valid_ignored: got %b required 00", {busy, in_ready});
      else n_pass++;
    end
    in_valid = 1'b0; last = 1'b0;
    start_epoch();
    send_point(1'b0, 16'd10, 16'd20, 16'd30, 16'd40, 1'b0);
    // Init write during ACC is ignored (model m_pub deliberately untouched).
    init_we = 1'b1; init_idx = 1'b0; init_dim = 2'd0; init_data = 16'd999;
    @(posedge clk); #1;
    init_we = 1'b0;
    n_total++;
    if (c00 !== m_pub[0]) $display("FAIL acc_init_ignored: got %0d required %0d", c00, m_pub[0]);
    else n_pass++;
    send_point(1'b1, 16'd7, 16'd7, 16'd7, 16'd7, 1'b0);
    send_point(1'b0, 16'd12, 16'd22, 16'd32, 16'd42, 1'b1);
    repeat (20) begin @(posedge clk); #1; end
    start = 1'b1; init_we = 1'b1; init_data = 16'd555;
    @(posedge clk); #1;
    start = 1'b0; init_we = 1'b0;
    n_total++;
    if ({busy, in_ready, done} !== 3'b100) $display("FAIL div_start_ignored: got %b required 100", {busy, in_ready, done});
    else n_pass++;
    wait_main_done(LAT + 50, cyc);
    n_total++;
    if (cyc + 21 != LAT) $display("FAIL div_start_latency: got %0d required %0d", cyc + 21, LAT);
    else n_pass++;
    n_total++;
    if ({c00, c13} !== {16'd11, 16'd7}) $display("FAIL ignored_result: got c0d0=%0d c1d3=%0d required 11,7", c00, c13);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_during_div();
    int ndone = 0;
    start_epoch();
    send_point(1'b0, 16'd30, 16'd30, 16'd30, 16'd30, 1'b1);
    repeat (50) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    m_pub = '0;
    #1;
    n_total++;
    if ({busy, done, c00, c10} !== '0) $display("FAIL div_reset: got busy=%b done=%b c0d0=%0d c1d0=%0d required all 0", busy, done, c00, c10);
    else n_pass++;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    n_total++;
    if (ndone != 0) $display("FAIL div_reset_no_done: got %0d pulses required 0", ndone);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int sat_at = -1;
    int main_at = -1;
    int cyc;
    init_all(1'b0, 16'd1);
    start_epoch();
    for (int i = 0; i < 4; i++) send_point(1'b0, 16'd8, 16'd8, 16'd8, 16'd8, i == 3);
    for (int i = 1; i <= LAT + 50; i++) begin
      @(posedge clk); #1;
      if (s_done && sat_at < 0) begin
        sat_at = i;
        for (int j = 0; j < 4; j++) begin
          n_total++;
          if (sat_c[j] !== 16'd8) $display("FAIL sat_c0[%0d]: got %0d required 8", j, sat_c[j]);
          else n_pass++;
        end
      end
      if (done) begin
        main_at = i;
        if (exp_q.size() != 0) m_pub = exp_q[0];
        break;
      end
    end
    n_total++;
    if (sat_at != LAT_SAT) $display("FAIL sat_latency: got %0d required %0d", sat_at, LAT_SAT);
    else n_pass++;
    n_total++;
    if (main_at != LAT) $display("FAIL sat_main_latency: got %0d required %0d", main_at, LAT);
    else n_pass++;
    n_total++;
    if ({s_overflow, overflow} !== 2'b10) $display("FAIL sat_overflow: got sat=%b main=%b required 1,0", s_overflow, overflow);
    else n_pass++;
    n_total++;
    if (sat_c[4] !== m_pub[4]) $display("FAIL sat_c1_kept: got %0d required %0d", sat_c[4], m_pub[4]);
    else n_pass++;
    @(posedge clk); #1;
    start_epoch();
    n_total++;
    if (s_overflow !== 1'b0) $display("FAIL sat_overflow_clear: got %b required 0", s_overflow);
    else n_pass++;
    send_point(1'b0, 16'd4, 16'd4, 16'd4, 16'd4, 1'b1);
    wait_main_done(LAT + 50, cyc);
    n_total++;
    if (cyc != LAT) $display("FAIL sat_followup_latency: got %0d required %0d", cyc, LAT);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; init_we = 1'b0; init_idx = 1'b0; init_dim = 2'd0; init_data = '0;
    start = 1'b0; in_valid = 1'b0; sel = 1'b0; last = 1'b0;
    d0 = '0; d1 = '0; d2 = '0; d3 = '0;
    m_pub = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic_mean();
    test_floor();
    test_empty_cluster();
    test_ignored_controls();
    test_reset_during_div();
    test_saturation();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kmeans_centroid_update_k2_d4.md
Name: kmeans_centroid_update_k2_d4

Overview:
Consumer end of the k=2, d=4 assignment pipeline. It accepts the classified point stream (point plus selected centroid index) and accumulates per-centroid coordinate sums and point counts over one epoch. At epoch end it computes new centroids as sum/count with a sequential divider, then publishes them to feed the next assignment pass.

Parameters:
input_data_width, 16, unsigned coordinate width
count_width, 16, per-centroid point counter width; sum width SW = input_data_width+count_width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
init_we  in  1  write initial centroid coordinate (honoured only in IDLE)
init_idx  in  1  centroid select for init write
init_dim  in  2  dimension select for init write
init_data  in  input_data_width  init coordinate value
start  in  1  begin epoch: clear accumulators, IDLE->ACC
in_valid  in  1  point valid
in_ready  out  1  high only in ACC
input_data0..3  in  input_data_width each  point coordinates
selected_centroid  in  1  centroid index of point
last  in  1  final point of epoch, qualified by in_valid&in_ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when new centroids are published
overflow  out  1  sticky; a point was dropped due to counter saturation
centroid0_d0..d3  out  input_data_width each  current centroid 0
centroid1_d0..d3  out  input_data_width each  current centroid 1

Behaviour:
- Reset (async, any state): state IDLE; all centroid outputs, sums, counts, and shadow quotients 0; in_ready, busy, done, overflow 0.
- States: IDLE, ACC, DIV, DONE.
- IDLE:
  - init_we writes init_data into centroid[init_idx][init_dim] at the clock edge.
  - start -> ACC. On the same edge clear 8 sums, 2 counts, and overflow.
  - start and init_we together: init write occurs and the state moves to ACC.
  - in_valid is ignored.
- ACC:
  - Handshake = in_valid&in_ready. On each handshake, for k = selected_centroid: sum[k][d] += input_data{d} for all d; count[k] += 1.
  - If count[k] is already 2^count_width-1, the point is dropped (sum and count held) and overflow is set.
  - Handshake with last=1 -> DIV on the same edge. The last point is accumulated.
  - start and init_we are ignored.
- DIV:
  - 8 division slots in order k0d0, k0d1, k0d2, k0d3, k1d0, k1d1, k1d2, k1d3.
  - Each slot takes exactly SW+1 cycles: 1 load cycle plus SW restoring-division iterations, 1 quotient bit per cycle, MSB first.
  - Unsigned floor division. The quotient's low input_data_width bits go to a shadow register; the mean cannot exceed the max coordinate, so no loss occurs.
  - If count[k]=0 (empty cluster), the slot still takes SW+1 cycles, but its shadow register is loaded with the current centroid value, so the old centroid is kept.
  - After 8*(SW+1) cycles -> DONE.
  - start, init_we, and in_valid are ignored.
- DONE (1 cycle):
  - All 8 centroid outputs load from the shadows on the entry edge, so the update is atomic.
  - done=1 for this single cycle; next edge -> IDLE.
- Latency: with the last handshake at edge N, done is high in the cycle after edge N+8*(SW+1). The default is 264 cycles.
- Centroid outputs change only on init writes in IDLE and on DONE entry. They are stable throughout ACC and DIV.
- Accumulators retain their values after DONE until the next start.

Test Plan:
1. Reset: assert rst mid-stream, then release -> all centroid outputs 0; busy=0, in_ready=0, done=0, overflow=0.
2. Basic mean:
   - Init c0=(0,0,0,0), c1=(50,50,50,50); start.
   - Stream k0:(2,4,6,8), k0:(4,6,8,10), k1:(10,10,10,10) with last on the third point.
   - Required: c0=(3,5,7,9), c1=(10,10,10,10); done exactly 264 cycles after the last handshake edge; busy=0 afterwards.
3. Floor rounding: k0 points (1,1,1,1),(2,2,2,2),(2,2,2,2) -> c0=(1,1,1,1), i.e. 5/3 floors to 1.
4. Empty cluster:
   - Init c1=(100,100,100,100); all points go to k0.
   - Required: c1 stays (100,100,100,100) and c0 equals the mean; DIV still takes 264 cycles.
5. Ignored controls:
   - in_valid in IDLE -> no accumulation.
   - start during DIV, and init_we during ACC -> state and outputs unchanged; centroid outputs stable during ACC and DIV.
   - rst during DIV -> immediate IDLE with outputs 0, and no done pulse.
6. Saturation (count_width=2):
   - Send 4 k0 points of 8; the 4th is last.
   - Required: overflow=1 and c0=(8,8,8,8), from 3 accepted points; overflow clears on the next start.
